// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the 784x10 inference sequencer.
// No logic; the helper gives start-to-done latency in cycles.
package nn_ctrl_pkg;

  localparam int NN_NUM_PIXELS  = 784;
  localparam int NN_NUM_CLASSES = 10;
  localparam int NN_CLASS_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_ARGMAX,
    S_DONE
  } nn_state_t;

  // Cycles from the edge sampling start to the cycle with done high.
  function automatic int nn_total_latency(input int pixels, input int pipe_lat, input int classes);
    return 1 + pixels + pipe_lat + 1 + classes;
  endfunction

endpackage

// File: rtl/argmax_seq.sv
// Sequential argmax, one class per step; best registers update on the step edge.
// nxt_* expose the post-step result so the caller can capture the final winner on the last step.
module argmax_seq
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES  = NN_NUM_CLASSES,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                                pclk,
  input  logic                                rst,
  input  logic                                first,
  input  logic                                step,
  input  logic [NN_CLASS_W-1:0]               idx,
  input  logic [NUM_CLASSES*RESULT_WIDTH-1:0] score_bus,
  output logic [NN_CLASS_W-1:0]               best_idx,
  output logic [RESULT_WIDTH-1:0]             best_val,
  output logic [NN_CLASS_W-1:0]               nxt_idx,
  output logic [RESULT_WIDTH-1:0]             nxt_val
);

  logic [RESULT_WIDTH-1:0] sel;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (idx == i[NN_CLASS_W-1:0]) sel = score_bus[i*RESULT_WIDTH +: RESULT_WIDTH];
    end
  end

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    nxt_idx = best_idx;
    nxt_val = best_val;
    if (step && (first || (sel > best_val))) begin
      nxt_idx = idx;
      nxt_val = sel;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      best_idx <= '0;
      best_val <= '0;
    end else begin
      best_idx <= nxt_idx;
      best_val <= nxt_val;
    end
  end

endmodule

// File: rtl/nn_infer_ctrl.sv
// Inference sequencer: stream pixels/ROM indices into the MAC bank, drain, argmax, pulse done.
// Fixed latency of 799 cycles from start to done with defaults; no backpressure, start ignored while busy.
module nn_infer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_PIXELS   = NN_NUM_PIXELS,
  parameter int NUM_CLASSES  = NN_NUM_CLASSES,
  parameter int WEIGHTS_ADDR = 10,
  parameter int GRAY_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int PIPE_LAT     = 3
) (
  input  logic                                pclk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [WEIGHTS_ADDR-1:0]             pix_rd_addr,
  input  logic [GRAY_WIDTH-1:0]               pix_rd_data,
  output logic [WEIGHTS_ADDR-1:0]             pixel_index,
  output logic [GRAY_WIDTH-1:0]               pixel_out,
  output logic                                mac_en,
  output logic                                mac_sload,
  input  logic [NUM_CLASSES*RESULT_WIDTH-1:0] score_bus,
  output logic [3:0]                          digit_out,
  output logic [RESULT_WIDTH-1:0]             max_score
);

  localparam logic [WEIGHTS_ADDR-1:0] ADDR_LAST  = WEIGHTS_ADDR'(NUM_PIXELS - 1);
  localparam logic [NN_CLASS_W-1:0]   DRAIN_LAST = NN_CLASS_W'(PIPE_LAT);
  localparam logic [NN_CLASS_W-1:0]   CLASS_LAST = NN_CLASS_W'(NUM_CLASSES - 1);

  nn_state_t                 state;
  logic [WEIGHTS_ADDR-1:0]   addr;
  logic [NN_CLASS_W-1:0]     cnt;
  logic                      am_step;
  logic                      am_first;
  logic [NN_CLASS_W-1:0]     best_idx;
  logic [RESULT_WIDTH-1:0]   best_val;
  logic [NN_CLASS_W-1:0]     nxt_idx;
  logic [RESULT_WIDTH-1:0]   nxt_val;

  assign pix_rd_addr = addr;
  assign pixel_index = addr;
  assign pixel_out   = pix_rd_data;
  assign am_step     = (state == S_ARGMAX);
  assign am_first    = am_step && (cnt == '0);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_en    <= 1'b0;
      mac_sload <= 1'b0;
      digit_out <= '0;
      max_score <= '0;
    end else begin
      // Frame buffer and weight ROM both have one cycle of read latency.
      mac_en    <= (state == S_STREAM);
      mac_sload <= (state == S_STREAM) && (addr == '0);
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          addr <= '0;
          cnt  <= '0;
          if (start) begin
            state <= S_STREAM;
            busy  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (addr == ADDR_LAST) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= S_ARGMAX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ARGMAX: begin
          // Capture the post-step winner so class 9 is included.
          if (cnt == CLASS_LAST) begin
            state     <= S_DONE;
            done      <= 1'b1;
            digit_out <= 4'(nxt_idx);
            max_score <= nxt_val;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  argmax_seq #(
    .NUM_CLASSES  (NUM_CLASSES),
    .RESULT_WIDTH (RESULT_WIDTH)
  ) u_argmax (
    .pclk      (pclk),
    .rst       (rst),
    .first     (am_first),
    .step      (am_step),
    .idx       (cnt),
    .score_bus (score_bus),
    .best_idx  (best_idx),
    .best_val  (best_val),
    .nxt_idx   (nxt_idx),
    .nxt_val   (nxt_val)
  );

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// Directed bench for nn_infer_ctrl: reset, full-run timing, argmax patterns, start filtering.
module tb_nn_infer_ctrl;

  logic         pclk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic [9:0]   pix_rd_addr;
  logic [7:0]   pix_rd_data;
  logic [9:0]   pixel_index;
  logic [7:0]   pixel_out;
  logic         mac_en;
  logic         mac_sload;
  logic [319:0] score_bus;
  logic [3:0]   digit_out;
  logic [31:0]  max_score;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  // Frame buffer model: registered read returning the low address byte.
  always @(posedge pclk) pix_rd_data <= pix_rd_addr[7:0];

  nn_infer_ctrl dut (
    .pclk        (pclk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .pix_rd_addr (pix_rd_addr),
    .pix_rd_data (pix_rd_data),
    .pixel_index (pixel_index),
    .pixel_out   (pixel_out),
    .mac_en      (mac_en),
    .mac_sload   (mac_sload),
    .score_bus   (score_bus),
    .digit_out   (digit_out),
    .max_score   (max_score)
  );

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full run; cycle c below is start-edge N plus c.
  task automatic run_frame(input string tag, input logic [319:0] sb, input bit pulses,
                           input logic [3:0] prev_digit, input logic [3:0] exp_digit,
                           input logic [31:0] exp_max);
    int bad_addr = 0, bad_en = 0, bad_sload = 0, bad_pix = 0, bad_busy = 0, bad_done = 0;
    int en_cycles = 0, done_cycles = 0;
    logic [7:0] ep;
    score_bus = sb;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 799; c++) begin
      if (c <= 784) begin
        if (pix_rd_addr !== 10'(c - 1) || pixel_index !== 10'(c - 1)) bad_addr++;
      end
      if (mac_en !== ((c >= 2) && (c <= 785))) bad_en++;
      if (mac_sload !== (c == 2)) bad_sload++;
      if (mac_en === 1'b1) begin
        en_cycles++;
        ep = 8'(c - 2);
        if (pixel_out !== ep) bad_pix++;
      end
      if (busy !== 1'b1) bad_busy++;
      if (done !== (c == 799)) bad_done++;
      if (done === 1'b1) done_cycles++;
      if (c == 400) begin
        check({tag, "_digit_hold"}, 64'(digit_out), 64'(prev_digit));
      end
      start = pulses && (c == 100 || c == 500);
      if (c < 799) tick();
    end
    start = 1'b0;
    check({tag, "_addr_seq"},   64'(bad_addr),    64'd0);
    check({tag, "_mac_en"},     64'(bad_en),      64'd0);
    check({tag, "_en_cycles"},  64'(en_cycles),   64'd784);
    check({tag, "_sload"},      64'(bad_sload),   64'd0);
    check({tag, "_pixel"},      64'(bad_pix),     64'd0);
    check({tag, "_busy"},       64'(bad_busy),    64'd0);
    check({tag, "_done_at799"}, 64'(bad_done),    64'd0);
    check({tag, "_done_count"}, 64'(done_cycles), 64'd1);
    check({tag, "_digit"},      64'(digit_out),   64'(exp_digit));
    check({tag, "_max"},        64'(max_score),   64'(exp_max));
    tick();
    check({tag, "_busy_after"}, 64'(busy),        64'd0);
    check({tag, "_done_after"}, 64'(done),        64'd0);
    check({tag, "_digit_keep"}, 64'(digit_out),   64'(exp_digit));
    check({tag, "_max_keep"},   64'(max_score),   64'(exp_max));
  endtask

  initial begin
    int done_n, sload_n;
    int done_at[2];
    int sload_at[2];

    rst = 1'b1;
    start = 1'b0;
    score_bus = '0;
    tick();
    tick();
    check("rst_busy",  64'(busy),        64'd0);
    check("rst_done",  64'(done),        64'd0);
    check("rst_en",    64'(mac_en),      64'd0);
    check("rst_sload", 64'(mac_sload),   64'd0);
    check("rst_addr",  64'(pix_rd_addr), 64'd0);
    check("rst_index", 64'(pixel_index), 64'd0);
    check("rst_digit", 64'(digit_out),   64'd0);
    check("rst_max",   64'(max_score),   64'd0);
    rst = 1'b0;
    tick();

    // Tie between class 1 and 3 at 9; stray starts mid-run must be ignored.
    run_frame("tie", {32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd3, 32'd9, 32'd5},
              1'b1, 4'd0, 4'd1, 32'd9);
    run_frame("zero", '0, 1'b0, 4'd1, 4'd0, 32'd0);
    run_frame("unsigned", {32'hFFFF_FFFF, {9{32'd1}}}, 1'b0, 4'd0, 4'd9, 32'hFFFF_FFFF);

    // Reset in the middle of streaming at address 400.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 401; c++) tick();
    check("mid_addr400", 64'(pix_rd_addr), 64'd400);
    check("mid_en_pre",  64'(mac_en),      64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy),        64'd0);
    check("mid_rst_en",   64'(mac_en),      64'd0);
    check("mid_rst_addr", 64'(pix_rd_addr), 64'd0);
    tick();
    check("mid_busy",  64'(busy),        64'd0);
    check("mid_en",    64'(mac_en),      64'd0);
    check("mid_sload", 64'(mac_sload),   64'd0);
    check("mid_done",  64'(done),        64'd0);
    check("mid_index", 64'(pixel_index), 64'd0);
    check("mid_digit", 64'(digit_out),   64'd0);
    check("mid_max",   64'(max_score),   64'd0);
    rst = 1'b0;
    tick();

    // Start held high: runs repeat every 800 cycles.
    score_bus = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0};
    start = 1'b1;
    tick();
    check("held_addr0",  64'(pix_rd_addr), 64'd0);
    check("held_sload1", 64'(mac_sload),   64'd0);
    done_n = 0;
    sload_n = 0;
    done_at[0] = 0;  done_at[1] = 0;
    sload_at[0] = 0; sload_at[1] = 0;
    for (int c = 1; c <= 1700; c++) begin
      if (done === 1'b1) begin
        if (done_n < 2) done_at[done_n] = c;
        done_n++;
      end
      if (mac_sload === 1'b1) begin
        if (sload_n < 2) sload_at[sload_n] = c;
        sload_n++;
      end
      tick();
    end
    start = 1'b0;
    check("held_done_n",   64'(done_n),      64'd2);
    check("held_done_0",   64'(done_at[0]),  64'd799);
    check("held_done_1",   64'(done_at[1]),  64'd1599);
    check("held_sload_n",  64'(sload_n),     64'd3);
    check("held_sload_0",  64'(sload_at[0]), 64'd2);
    check("held_sload_1",  64'(sload_at[1]), 64'd802);
    check("held_digit",    64'(digit_out),   64'd4);
    check("held_max",      64'(max_score),   64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_infer_ctrl.md
# nn_infer_ctrl

Sequencer for the 784×10 weights-multiply datapath. On `start` it streams every pixel of the frame buffer and its matching weight-ROM index into the multiply-accumulate bank, with correct alignment. It clears the accumulators on the first product, waits for the pipeline to drain, then runs a sequential argmax over the ten class scores. It sits between the frame-capture/gray-scale buffer and the recognition result display.

## Interface
- `NUM_PIXELS`, 784, pixels per frame / ROM depth used
- `NUM_CLASSES`, 10, number of score inputs
- `WEIGHTS_ADDR`, 10, width of pixel/ROM index
- `GRAY_WIDTH`, 8, pixel width
- `RESULT_WIDTH`, 32, width of each accumulator score
- `PIPE_LAT`, 3, cycles from a data-valid pixel at the MAC input to its contribution appearing on the score bus

Ports:
- `pclk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request one inference; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` is high, inclusive
- `done`  out  1  one-cycle pulse; result valid
- `pix_rd_addr`  out  WEIGHTS_ADDR  frame-buffer read address (1-cycle read latency)
- `pix_rd_data`  in  GRAY_WIDTH  frame-buffer read data
- `pixel_index`  out  WEIGHTS_ADDR  weight-ROM address (registered ROM, 1-cycle latency); equals `pix_rd_addr`
- `pixel_out`  out  GRAY_WIDTH  pixel to MAC bank
- `mac_en`  out  1  MAC clock-enable; high only when `pixel_out` and ROM data are a valid pair
- `mac_sload`  out  1  accumulator load (discard prior sum); high with the first valid pair only
- `score_bus`  in  NUM_CLASSES*RESULT_WIDTH  packed scores, class 0 in LSBs
- `digit_out`  out  4  winning class
- `max_score`  out  RESULT_WIDTH  winning score

## Operation
- FSM states: IDLE → STREAM → DRAIN → ARGMAX → DONE → IDLE.
- **IDLE:** `start` moves the FSM to STREAM. Address counter is cleared.
- **STREAM:** lasts NUM_PIXELS cycles.
  - `pix_rd_addr` = `pixel_index` = counter, 0…NUM_PIXELS-1, incrementing each cycle.
  - On the last address the FSM goes to DRAIN. The counter does not wrap past NUM_PIXELS-1.
- **Data path alignment:**
  - `pixel_out` = `pix_rd_data`, combinational passthrough.
  - `mac_en` = 1-cycle-delayed "address issued" flag.
  - `mac_sload` = 1-cycle-delayed "address==0 issued" flag.
- **DRAIN:** lasts PIPE_LAT+1 cycles (one for the read latency, PIPE_LAT for the MAC). Then the FSM goes to ARGMAX.
- **ARGMAX:** lasts NUM_CLASSES cycles, examining class i in cycle i.
  - Class 0 is loaded unconditionally.
  - Class i>0 replaces the current best only if score_i > best, compared unsigned.
  - Ties keep the lower index.
- **DONE:** lasts one cycle.
  - `done`=1.
  - `digit_out`/`max_score` are updated from the best registers at entry and hold until the next DONE.
- `start` while busy is ignored (not queued). `start` held high in IDLE after DONE starts a new run.
- `rst` at any time forces IDLE asynchronously and aborts any run. Partial accumulator contents are not cleared, because the next run's `mac_sload` discards them.

## Timing
- Reset values: `busy`, `done`, `mac_en`, `mac_sload`, `pix_rd_addr`, `pixel_index`, `digit_out`, `max_score` all 0.
- With `start` sampled at edge N:
  - Address k is issued in cycle N+1+k.
  - `mac_en` is high in cycles N+2 … N+1+NUM_PIXELS.
  - `mac_sload` is high in cycle N+2 only.
  - `done` is high in cycle N+1+NUM_PIXELS+PIPE_LAT+1+NUM_CLASSES, which is N+799 with defaults.
- Back-to-back runs: minimum start-to-start spacing is 800 cycles.
- `score_bus` is sampled only in ARGMAX; it is stable then because `mac_en` is low.

## Structure
- Package `nn_ctrl_pkg` holds:
  - state enum `nn_state_t` (IDLE, STREAM, DRAIN, ARGMAX, DONE)
  - constants `NN_NUM_PIXELS`=784 and `NN_NUM_CLASSES`=10
  - a function returning the total latency
- One sub-module: `argmax_seq`, the sequential comparator with best-index/best-value registers, `first` and `step` controls, and the score mux.
- FSM, counters and alignment delays stay in the top level.

## Test plan
- Reset mid-STREAM at address 400 → next cycle `busy`=0, `mac_en`=0, all outputs 0. A following `start` issues address 0 again and asserts `mac_sload` at N+2.
- Single run, frame buffer model returning pixel = addr[7:0] → `pix_rd_addr` counts 0…783, `pixel_out` in cycle N+2+k equals k[7:0], `mac_en` high exactly 784 cycles, `done` at N+799.
- Scores {5,9,3,9,0,0,0,0,0,1} → `digit_out`=1, `max_score`=9 (tie with class 3 keeps lower index).
- Scores all 0 → `digit_out`=0, `max_score`=0. Class 9 = 0xFFFF_FFFF, others 1 → `digit_out`=9 (unsigned compare).
- `start` pulsed at N+100 and N+500 during a run → ignored, exactly one `done`. `start` held high continuously → `done` pulses every 800 cycles with `mac_sload` at each run start.
